expansion_input_filter: RTL and testbench



---
 rtl/expansion_pkg.sv | 22 ++
 rtl/expansion_filter_bit.sv | 96 +++++++++
 rtl/expansion_input_filter.sv | 61 ++++++
 tb/tb_expansion_input_filter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/expansion_pkg.sv
// Shared constants and width helpers for the expansion input path.
package expansion_pkg;

  localparam int unsigned EXP_WIDTH    = 8;
  localparam int unsigned EXP_TICK_DIV = 1000;
  localparam int unsigned EXP_DEBOUNCE = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Counters need at least one bit even when clog2 collapses to 0.
  function automatic int unsigned width_for(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/expansion_filter_bit.sv
// One expansion input bit: sync, debounce counter, edge pulses, sticky latch.
// Sticky latches exist only when EXPANSION_FILTER_STICKY_EN is defined.
module expansion_filter_bit
  import expansion_pkg::*;
#(
  parameter int unsigned DEBOUNCE = EXP_DEBOUNCE,
  parameter logic        INIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  input  logic clear,
  output logic filtered,
  output logic rise,
  output logic fall,
  output logic sticky_rise,
  output logic sticky_fall
);

  logic s1;
  logic filt_d;

  always_ff @(posedge clk) begin
    if (rst) s1 <= INIT;
    else     s1 <= raw;
  end

  generate
    if (DEBOUNCE == 0) begin : g_pass
      // The filtered flop doubles as the second sync stage.
      logic unused_tick;
      assign unused_tick = tick;

      always_ff @(posedge clk) begin
        if (rst) filtered <= INIT;
        else     filtered <= s1;
      end
    end else begin : g_deb
      localparam int unsigned CW = width_for(DEBOUNCE + 1);
      localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE);

      logic          s2;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2       <= INIT;
          cnt      <= '0;
          filtered <= INIT;
        end else begin
          s2 <= s1;
          if (s2 == filtered) begin
            cnt <= '0;
          end else if (cnt == DMAX) begin
            filtered <= s2;
            cnt      <= '0;
          end else if (tick) begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_d <= INIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      filt_d <= filtered;
      rise   <= filtered & ~filt_d;
      fall   <= ~filtered & filt_d;
    end
  end

`ifdef EXPANSION_FILTER_STICKY_EN
  // A new event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_rise <= 1'b0;
      sticky_fall <= 1'b0;
    end else begin
      sticky_rise <= rise | (sticky_rise & ~clear);
      sticky_fall <= fall | (sticky_fall & ~clear);
    end
  end
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign sticky_rise  = 1'b0;
  assign sticky_fall  = 1'b0;
`endif

endmodule

// File: rtl/expansion_input_filter.sv
// Debounced level/edge front end for the shift-register expansion inputs.
// Optional sticky edge latches: EXPANSION_FILTER_STICKY_EN.
module expansion_input_filter
  import expansion_pkg::*;
#(
  parameter int unsigned      WIDTH    = EXP_WIDTH,
  parameter int unsigned      TICK_DIV = EXP_TICK_DIV,
  parameter int unsigned      DEBOUNCE = EXP_DEBOUNCE,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] filtered,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] sticky_rise,
  output logic [WIDTH-1:0] sticky_fall,
  input  logic [WIDTH-1:0] clear
);

  logic tick;

  generate
    if (DEBOUNCE == 0) begin : g_no_pre
      assign tick = 1'b0;
    end else begin : g_pre
      localparam int unsigned PW = width_for(TICK_DIV);
      localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

      logic [PW-1:0] pre;

      assign tick = (pre == PMAX);

      always_ff @(posedge clk) begin
        if (rst)       pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PW'(1);
      end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      expansion_filter_bit #(
        .DEBOUNCE(DEBOUNCE),
        .INIT    (INIT[i])
      ) u_bit (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .raw        (raw_in[i]),
        .clear      (clear[i]),
        .filtered   (filtered[i]),
        .rise       (rise[i]),
        .fall       (fall[i]),
        .sticky_rise(sticky_rise[i]),
        .sticky_fall(sticky_fall[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_expansion_input_filter.sv
// Scoreboarded bench for expansion_input_filter: debounce, INIT and pass-through.
module tb_expansion_input_filter;

`ifdef EXPANSION_FILTER_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] raw_m, clr_m, filt_m, rise_m, fall_m, sr_m, sf_m;
  logic [7:0] raw_i, filt_i, rise_i, fall_i, sr_i, sf_i;
  logic [7:0] raw_p, filt_p, rise_p, fall_p, sr_p, sf_p;

  expansion_input_filter #(
    .WIDTH(8), .TICK_DIV(4), .DEBOUNCE(3), .INIT(8'h00)
  ) u_main (
    .clk(clk), .rst(rst), .raw_in(raw_m), .filtered(filt_m),
    .rise(rise_m), .fall(fall_m), .sticky_rise(sr_m),
    .sticky_fall(sf_m), .clear(clr_m)
  );

  expansion_input_filter #(
    .WIDTH(8), .TICK_DIV(4), .DEBOUNCE(3), .INIT(8'hA5)
  ) u_init (
    .clk(clk), .rst(rst), .raw_in(raw_i), .filtered(filt_i),
    .rise(rise_i), .fall(fall_i), .sticky_rise(sr_i),
    .sticky_fall(sf_i), .clear(8'h00)
  );

  expansion_input_filter #(
    .WIDTH(8), .TICK_DIV(1), .DEBOUNCE(0), .INIT(8'h00)
  ) u_pass (
    .clk(clk), .rst(rst), .raw_in(raw_p), .filtered(filt_p),
    .rise(rise_p), .fall(fall_p), .sticky_rise(sr_p),
    .sticky_fall(sf_p), .clear(8'h00)
  );

  typedef struct {
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] filt;
    int         lo;
    int         hi;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;

  logic [7:0] pv [8] = '{8'h3C, 8'h81, 8'hFF, 8'h00,
                         8'h5A, 8'hA5, 8'h0F, 8'hF0};

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge seen 13..16 negedges after the raw change (2 sync + 3 ticks + 2).
  task automatic expect_ev(input logic [7:0] r, input logic [7:0] f,
                           input logic [7:0] flt);
    ev_t e;
    e.rise = r;
    e.fall = f;
    e.filt = flt;
    e.lo   = cyc + 13;
    e.hi   = cyc + 16;
    sb.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if ((rise_m | fall_m) != 8'h00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_edge rise %h fall %h cyc %0d",
                 rise_m, fall_m, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("edge_rise", rise_m, mon_e.rise);
        chk("edge_fall", fall_m, mon_e.fall);
        chk("edge_filt", filt_m, mon_e.filt);
        checks++;
        if (cyc < mon_e.lo || cyc > mon_e.hi) begin
          errors++;
          $display("FAIL edge_time got %0d want %0d..%0d",
                   cyc, mon_e.lo, mon_e.hi);
        end
      end
    end
  end

  initial begin
    bit found;
    rst   = 1'b1;
    raw_m = 8'h00;
    clr_m = 8'h00;
    raw_i = 8'h00;
    raw_p = 8'h00;

    repeat (3) begin
      @(negedge clk);
      chk("init_filt", filt_i, 8'hA5);
      chk("init_edges", rise_i | fall_i | sr_i | sf_i, 8'h00);
      chk("rst_filt_m", filt_m, 8'h00);
    end
    raw_i = 8'hA5;
    rst   = 1'b0;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("pass_filt", filt_p, (k >= 2) ? pv[k-2] : 8'h00);
      if (k < 8) raw_p = pv[k];
    end

    @(negedge clk);
    raw_m = 8'h01;
    expect_ev(8'h01, 8'h00, 8'h01);
    wait_n(22);
    chk("stable_filt", filt_m, 8'h01);

    raw_m = 8'h09;
    wait_n(6);
    raw_m = 8'h01;
    wait_n(22);
    chk("glitch_filt", filt_m, 8'h01);

    raw_m = 8'h09;
    expect_ev(8'h08, 8'h00, 8'h09);
    wait_n(22);
    chk("after_glitch_filt", filt_m, 8'h09);

    raw_m = 8'h0F;
    expect_ev(8'h06, 8'h00, 8'h0F);
    wait_n(22);
    chk("sticky_r_0f", sr_m, STK ? 8'h0F : 8'h00);
    chk("sticky_f_00", sf_m, 8'h00);

    raw_m = 8'hF0;
    expect_ev(8'hF0, 8'h0F, 8'hF0);
    wait_n(22);
    chk("multi_filt", filt_m, 8'hF0);
    chk("sticky_r_ff", sr_m, STK ? 8'hFF : 8'h00);
    chk("sticky_f_0f", sf_m, STK ? 8'h0F : 8'h00);

    clr_m = 8'h04;
    @(negedge clk);
    clr_m = 8'h00;
    chk("sticky_clr", sr_m, STK ? 8'hFB : 8'h00);
    chk("sticky_clr_f", sf_m, STK ? 8'h0B : 8'h00);

    raw_m = 8'hF4;
    expect_ev(8'h04, 8'h00, 8'hF4);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (rise_m[2]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rise2_wait got timeout want rise[2]");
    end
    clr_m = 8'h04;
    @(negedge clk);
    clr_m = 8'h00;
    chk("set_wins", sr_m, STK ? 8'hFF : 8'h00);
    wait_n(5);
    chk("sticky_hold", sr_m, STK ? 8'hFF : 8'h00);
    wait_n(20);

    raw_m = 8'hF5;
    wait_n(8);
    rst = 1'b1;
    wait_n(2);
    chk("midrst_filt", filt_m, 8'h00);
    chk("midrst_sr", sr_m, 8'h00);
    chk("midrst_sf", sf_m, 8'h00);
    rst = 1'b0;
    expect_ev(8'hF5, 8'h00, 8'hF5);
    wait_n(10);
    chk("fresh_count", filt_m, 8'h00);
    wait_n(12);
    chk("fresh_done", filt_m, 8'hF5);
    chk("init_final", filt_i, 8'hA5);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
